// File: rtl/sdcard_pkg.sv
// Shared encodings for the SD card initialisation sequencer: FSM states, command
// indices, fixed command arguments, failure codes and detected card types.
package sdcard_pkg;

   localparam logic [3:0] StIdle   = 4'd0;
   localparam logic [3:0] StCmd0   = 4'd1;
   localparam logic [3:0] StCmd8   = 4'd2;
   localparam logic [3:0] StCmd55  = 4'd3;
   localparam logic [3:0] StAcmd41 = 4'd4;
   localparam logic [3:0] StCmd2   = 4'd5;
   localparam logic [3:0] StCmd3   = 4'd6;
   localparam logic [3:0] StCmd7   = 4'd7;
   localparam logic [3:0] StDone   = 4'd8;
   localparam logic [3:0] StErr    = 4'd9;

   localparam logic [5:0] CmdGoIdle      = 6'd0;
   localparam logic [5:0] CmdSendIfCond  = 6'd8;
   localparam logic [5:0] CmdAppCmd      = 6'd55;
   localparam logic [5:0] AcmdSendOpCond = 6'd41;
   localparam logic [5:0] CmdAllSendCid  = 6'd2;
   localparam logic [5:0] CmdSendRelAddr = 6'd3;
   localparam logic [5:0] CmdSelectCard  = 6'd7;

   localparam logic [31:0] Cmd8Arg     = 32'h0000_01AA;
   localparam logic [31:0] Acmd41ArgV2 = 32'h4030_0000;
   localparam logic [31:0] Acmd41ArgV1 = 32'h0030_0000;
   localparam logic [15:0] PreCntStd   = 16'd8;

   localparam logic [2:0] ErrNone      = 3'd0;
   localparam logic [2:0] ErrBadEcho   = 3'd1;
   localparam logic [2:0] ErrAcmd41Max = 3'd2;
   localparam logic [2:0] ErrTimeout   = 3'd3;
   localparam logic [2:0] ErrSyntax    = 3'd4;

   localparam logic [1:0] CardNone   = 2'd0;
   localparam logic [1:0] CardSdv1   = 2'd1;
   localparam logic [1:0] CardSdv2Sc = 2'd2;
   localparam logic [1:0] CardSdhc   = 2'd3;

   function automatic logic [5:0] cmd_index(input logic [3:0] st);
      case (st)
         StCmd8:   return CmdSendIfCond;
         StCmd55:  return CmdAppCmd;
         StAcmd41: return AcmdSendOpCond;
         StCmd2:   return CmdAllSendCid;
         StCmd3:   return CmdSendRelAddr;
         StCmd7:   return CmdSelectCard;
         default:  return CmdGoIdle;
      endcase
   endfunction

endpackage

// File: rtl/sdcard_init_seq.sv
// SD card identification sequencer: drives the command engine through
// CMD0/CMD8/(CMD55+ACMD41)*/CMD2/CMD3/CMD7 and reports card type, RCA and status.
module sdcard_init_seq
   import sdcard_pkg::*;
#(
   parameter logic [15:0] SLOW_DIV   = 16'd60,
   parameter logic [15:0] FAST_DIV   = 16'd1,
   parameter int unsigned ACMD41_MAX = 1000,
   parameter logic [15:0] PRE_CNT    = 16'd96
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        init_start,
   output logic        busy,
   output logic        ready,
   output logic        error,
   output logic [2:0]  err_code,
   output logic [1:0]  card_type,
   output logic [15:0] rca,
   output logic [15:0] clkdiv,
   output logic        cmd_start,
   output logic [15:0] cmd_precnt,
   output logic [5:0]  cmd_idx,
   output logic [31:0] cmd_arg,
   input  logic        cmd_busy,
   input  logic        cmd_done,
   input  logic        cmd_timeout,
   input  logic        cmd_syntaxe,
   input  logic [31:0] cmd_resparg
);

   localparam int unsigned CntW = $clog2(ACMD41_MAX + 1);

   logic [3:0]      state_q, state_d;
   logic            wait_q, wait_d;
   logic            v2_q, v2_d;
   logic [CntW-1:0] attempts_q, attempts_d;
   logic            ready_q, ready_d;
   logic            error_q, error_d;
   logic [2:0]      err_code_q, err_code_d;
   logic [1:0]      card_type_q, card_type_d;
   logic [15:0]     rca_q, rca_d;
   logic [15:0]     clkdiv_q, clkdiv_d;
   logic            cmd_start_q, cmd_start_d;
   logic [5:0]      cmd_idx_q, cmd_idx_d;
   logic [31:0]     cmd_arg_q, cmd_arg_d;
   logic [15:0]     cmd_precnt_q, cmd_precnt_d;

   logic [31:0] arg_sel;
   logic        fault;
   logic [2:0]  fault_code;
   logic        unused_resp;

   assign unused_resp = ^cmd_resparg[15:12];

   // Response faults that abort the commands where R1 status is meaningful.
   assign fault      = cmd_timeout | cmd_syntaxe;
   assign fault_code = cmd_timeout ? ErrTimeout : ErrSyntax;

   always_comb begin
      case (state_q)
         StCmd8:   arg_sel = Cmd8Arg;
         StAcmd41: arg_sel = v2_q ? Acmd41ArgV2 : Acmd41ArgV1;
         StCmd7:   arg_sel = {rca_q, 16'h0000};
         default:  arg_sel = 32'h0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      v2_d         = v2_q;
      attempts_d   = attempts_q;
      ready_d      = ready_q;
      error_d      = error_q;
      err_code_d   = err_code_q;
      card_type_d  = card_type_q;
      rca_d        = rca_q;
      clkdiv_d     = clkdiv_q;
      cmd_start_d  = 1'b0;
      cmd_idx_d    = cmd_idx_q;
      cmd_arg_d    = cmd_arg_q;
      cmd_precnt_d = cmd_precnt_q;

      case (state_q)
         StIdle: begin
            if (init_start) begin
               ready_d     = 1'b0;
               error_d     = 1'b0;
               err_code_d  = ErrNone;
               card_type_d = CardNone;
               rca_d       = 16'h0;
               clkdiv_d    = SLOW_DIV;
               attempts_d  = '0;
               v2_d        = 1'b0;
               wait_d      = 1'b0;
               state_d     = StCmd0;
            end
         end
         StDone: begin
            ready_d  = 1'b1;
            clkdiv_d = FAST_DIV;
            state_d  = StIdle;
         end
         StErr: begin
            error_d  = 1'b1;
            clkdiv_d = SLOW_DIV;
            state_d  = StIdle;
         end
         StCmd0, StCmd8, StCmd55, StAcmd41, StCmd2, StCmd3, StCmd7: begin
            if (!wait_q) begin
               if (!cmd_busy) begin
                  cmd_start_d  = 1'b1;
                  cmd_idx_d    = cmd_index(state_q);
                  cmd_arg_d    = arg_sel;
                  cmd_precnt_d = (state_q == StCmd0) ? PRE_CNT : PreCntStd;
                  wait_d       = 1'b1;
               end
            end else if (cmd_done) begin
               wait_d = 1'b0;
               case (state_q)
                  StCmd0: state_d = StCmd8;
                  StCmd8: begin
                     // No CMD8 response marks a v1 card; a wrong echo is fatal.
                     if (cmd_timeout || cmd_resparg[11:0] == 12'h1AA) begin
                        v2_d    = !cmd_timeout;
                        state_d = StCmd55;
                     end else begin
                        err_code_d = ErrBadEcho;
                        state_d    = StErr;
                     end
                  end
                  StCmd55: begin
                     if (fault) begin
                        err_code_d = fault_code;
                        state_d    = StErr;
                     end else begin
                        state_d = StAcmd41;
                     end
                  end
                  StAcmd41: begin
                     if (cmd_timeout) begin
                        err_code_d = ErrTimeout;
                        state_d    = StErr;
                     end else if (cmd_resparg[31]) begin
                        card_type_d = !v2_q ? CardSdv1 :
                                      (cmd_resparg[30] ? CardSdhc : CardSdv2Sc);
                        state_d     = StCmd2;
                     end else begin
                        attempts_d = attempts_q + CntW'(1);
                        if (32'(attempts_q) + 32'd1 >= ACMD41_MAX) begin
                           err_code_d = ErrAcmd41Max;
                           state_d    = StErr;
                        end else begin
                           state_d = StCmd55;
                        end
                     end
                  end
                  StCmd2: begin
                     if (cmd_timeout) begin
                        err_code_d = ErrTimeout;
                        state_d    = StErr;
                     end else begin
                        state_d = StCmd3;
                     end
                  end
                  StCmd3: begin
                     if (fault) begin
                        err_code_d = fault_code;
                        state_d    = StErr;
                     end else begin
                        rca_d   = cmd_resparg[31:16];
                        state_d = StCmd7;
                     end
                  end
                  StCmd7: begin
                     if (fault) begin
                        err_code_d = fault_code;
                        state_d    = StErr;
                     end else begin
                        state_d = StDone;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: begin
            wait_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         wait_q       <= 1'b0;
         v2_q         <= 1'b0;
         attempts_q   <= '0;
         ready_q      <= 1'b0;
         error_q      <= 1'b0;
         err_code_q   <= ErrNone;
         card_type_q  <= CardNone;
         rca_q        <= 16'h0;
         clkdiv_q     <= SLOW_DIV;
         cmd_start_q  <= 1'b0;
         cmd_idx_q    <= 6'h0;
         cmd_arg_q    <= 32'h0;
         cmd_precnt_q <= 16'h0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         v2_q         <= v2_d;
         attempts_q   <= attempts_d;
         ready_q      <= ready_d;
         error_q      <= error_d;
         err_code_q   <= err_code_d;
         card_type_q  <= card_type_d;
         rca_q        <= rca_d;
         clkdiv_q     <= clkdiv_d;
         cmd_start_q  <= cmd_start_d;
         cmd_idx_q    <= cmd_idx_d;
         cmd_arg_q    <= cmd_arg_d;
         cmd_precnt_q <= cmd_precnt_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign ready      = ready_q;
   assign error      = error_q;
   assign err_code   = err_code_q;
   assign card_type  = card_type_q;
   assign rca        = rca_q;
   assign clkdiv     = clkdiv_q;
   assign cmd_start  = cmd_start_q;
   assign cmd_idx    = cmd_idx_q;
   assign cmd_arg    = cmd_arg_q;
   assign cmd_precnt = cmd_precnt_q;

endmodule

// File: doc/sdcard_init_seq.md
SDCARD_INIT_SEQ -- requirements
Module: sdcard_init_seq

Interface
REQ-001 Parameter SLOW_DIV, default 16'd60, clkdiv during identification (about 400 kHz at 50 MHz).
REQ-002 Parameter FAST_DIV, default 16'd1, clkdiv after successful init.
REQ-003 Parameter ACMD41_MAX, default 1000, maximum CMD55/ACMD41 attempt pairs.
REQ-004 Parameter PRE_CNT, default 16'd96, precnt for CMD0 (at least 74 power-up clocks); all other commands use precnt 16'd8.
REQ-005 clk  in  1  system clock.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 init_start  in  1  one-cycle request to run the init sequence.
REQ-008 busy  out  1  sequence in progress.
REQ-009 ready  out  1  card initialised; level output.
REQ-010 error  out  1  init failed; level output.
REQ-011 err_code  out  3  failure cause.
REQ-012 card_type  out  2  0 none, 1 SDv1, 2 SDv2-SC, 3 SDHC/XC.
REQ-013 rca  out  16  relative card address from CMD3.
REQ-014 clkdiv  out  16  to command engine clkdiv.
REQ-015 cmd_start, cmd_precnt[15:0], cmd_idx[5:0], cmd_arg[31:0]  out  request to command engine.
REQ-016 cmd_busy, cmd_done, cmd_timeout, cmd_syntaxe  in  1 each  engine status; cmd_done is a 1-cycle pulse.
REQ-017 cmd_resparg  in  32  response argument, valid on cmd_done.

Function
REQ-018 States SHALL be: IDLE, CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3, CMD7, DONE, ERR; each command state has ISSUE and WAIT phases.
REQ-019 In ISSUE with cmd_busy=0, the block SHALL assert cmd_start for exactly 1 cycle with cmd_idx/cmd_arg/cmd_precnt stable, then enter WAIT.
REQ-020 cmd_idx/cmd_arg/cmd_precnt SHALL hold from ISSUE until cmd_done.
REQ-021 WAIT SHALL advance only on cmd_done; the next ISSUE SHALL wait until cmd_busy=0.
REQ-022 IDLE + init_start SHALL: clear ready/error, set card_type=0, rca=0, clkdiv=SLOW_DIV, and go to CMD0. init_start SHALL be ignored while busy.
REQ-023 CMD0: arg 0, precnt PRE_CNT; any completion, including timeout, SHALL go to CMD8.
REQ-024 CMD8: arg 32'h000001AA. Timeout -> v1 path, then CMD55. cmd_resparg[11:0]==12'h1AA -> v2 path, then CMD55. Any other value -> ERR, code 1.
REQ-025 CMD55: arg 0; timeout or syntaxe -> ERR, code 3 or 4.
REQ-026 ACMD41: arg 32'h40300000 on v2 path, 32'h00300000 on v1 path; cmd_syntaxe SHALL be ignored (R3).
REQ-027 ACMD41 resparg[31]=0 SHALL increment the attempt counter and return to CMD55; reaching ACMD41_MAX -> ERR, code 2.
REQ-028 ACMD41 resparg[31]=1 SHALL set card_type: 1 if v1; 3 if v2 and resparg[30]=1; otherwise 2. Next state CMD2.
REQ-029 CMD2: arg 0; only timeout is an error (code 3), syntaxe ignored (R2).
REQ-030 CMD3: arg 0; rca SHALL be set to resparg[31:16].
REQ-031 CMD7: arg {rca,16'h0}; success -> DONE.
REQ-032 ACMD41 timeout -> code 3. CMD3/CMD7 timeout or syntaxe -> code 3 or 4.
REQ-033 DONE SHALL set ready=1 and clkdiv=FAST_DIV, then go to IDLE.
REQ-034 ERR SHALL set error=1, keep clkdiv=SLOW_DIV, then go to IDLE.
REQ-035 busy SHALL be 1 in every state except IDLE.
REQ-036 A new init_start from IDLE after ERR or DONE SHALL restart the sequence from CMD0.

Reset
REQ-037 Asynchronous reset SHALL force: state IDLE, busy=0, ready=0, error=0, err_code=0, card_type=0, rca=0, clkdiv=SLOW_DIV, cmd_start=0, cmd_idx=0, cmd_arg=0, cmd_precnt=0, attempt counter=0.
REQ-038 Reset mid-sequence SHALL abandon the sequence with no further cmd_start.

Structure
REQ-039 A shared package sdcard_pkg SHALL hold the state encoding, command index constants, err_code values (0 none, 1 bad CMD8 echo, 2 ACMD41 exhausted, 3 timeout, 4 syntax) and card_type values.
REQ-040 No sub-module; the block connects beside the command engine in the SD wrapper.

Verification
REQ-041 SDHC model: CMD8 echo 0x1AA, ACMD41 busy twice then 0xC0FF8000 -> card_type=3, ready=1, clkdiv=FAST_DIV, 3 CMD55/ACMD41 pairs.
REQ-042 CMD8 timeout, ACMD41 0x80FF8000 -> card_type=1; ACMD41 arg 0x00300000.
REQ-043 CMD8 echo 0x0155 -> error=1, err_code=1, no further cmd_start.
REQ-044 ACMD41 always busy, ACMD41_MAX=4 -> err_code=2 after exactly 4 pairs.
REQ-045 CMD3 resparg 0xB3680500 -> rca=0xB368, CMD7 arg 0xB3680000.
REQ-046 rstn low during ACMD41 WAIT -> all outputs at reset values; a later init_start restarts at CMD0 with precnt 96.
